// File: rtl/quadra_sweep_pkg.sv
// Shared types for the quadra sweep controller and its result FIFO.
// Holds the x/y widths, the FSM state enum and the tag/result bundles.
package quadra_sweep_pkg;

  localparam int X_W        = 24;
  localparam int Y_W        = 48;
  localparam int QUADRA_LAT = 3;

  typedef logic           ck_t;
  typedef logic           rs_t;
  typedef logic [X_W-1:0] x_t;
  typedef logic [Y_W-1:0] y_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN
  } sweep_state_t;

  typedef struct packed {
    logic valid;
    x_t   x;
    logic last;
  } sweep_tag_t;

  typedef struct packed {
    x_t   x;
    y_t   y;
    logic last;
  } sweep_res_t;

endpackage

// File: rtl/quadra_res_fifo.sv
// First-word-fall-through result FIFO, falling-edge clocked.
// Ports: push/push_data in, pop in, head (FWFT entry) and count out.
module quadra_res_fifo
  import quadra_sweep_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  ck_t                      clk,
  input  rs_t                      rst_b,
  input  logic                     push,
  input  sweep_res_t               push_data,
  input  logic                     pop,
  output sweep_res_t               head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  sweep_res_t      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_pop;
  logic            full;

  assign do_pop = pop && (count != '0);
  assign full   = (count == DEPTH[AW:0]);
  assign head   = mem[rd_ptr];

  always_ff @(negedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, push}
                     - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(negedge clk) begin
    if (push)
      mem[wr_ptr] <= push_data;
  end

  // Issue credit keeps this from ever firing.
  no_overflow: assert property (
    @(negedge clk) disable iff (!rst_b)
    !(push && !do_pop && full));

endmodule

// File: rtl/quadra_sweep_ctrl.sv
// Sweep engine: issues x values to quadra, tags them through its latency,
// queues {x,y,last} results and drains them over a valid/ready stream.
module quadra_sweep_ctrl
  import quadra_sweep_pkg::x_t;
  import quadra_sweep_pkg::y_t;
  import quadra_sweep_pkg::ck_t;
  import quadra_sweep_pkg::rs_t;
  import quadra_sweep_pkg::sweep_state_t;
  import quadra_sweep_pkg::S_IDLE;
  import quadra_sweep_pkg::S_ISSUE;
  import quadra_sweep_pkg::S_DRAIN;
  import quadra_sweep_pkg::sweep_tag_t;
  import quadra_sweep_pkg::sweep_res_t;
#(
  parameter int QUADRA_LAT = quadra_sweep_pkg::QUADRA_LAT,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input  ck_t              clk,
  input  rs_t              rst_b,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  x_t               cmd_start,
  input  x_t               cmd_step,
  input  logic [CNT_W-1:0] cmd_count,
  output x_t               q_x,
  input  y_t               q_y,
  output logic             out_valid,
  input  logic             out_ready,
  output x_t               out_x,
  output y_t               out_y,
  output logic             out_last,
  output logic             busy,
  output logic             done
);

  localparam int PW = $clog2(FIFO_DEPTH + QUADRA_LAT + 2) + 1;
  localparam int FW = $clog2(FIFO_DEPTH);

  sweep_state_t     state_q;
  sweep_state_t     state_d;
  sweep_tag_t       tag_q [QUADRA_LAT+1];
  x_t               step_q;
  x_t               x_nxt;
  logic [CNT_W-1:0] rem_q;
  logic             done_q;
  logic             done_d;
  logic             issue;
  logic             load;
  logic             last_iss;
  logic             credit_ok;
  logic             pop;
  logic             push;
  logic [PW-1:0]    inflight;
  logic [FW:0]      fifo_cnt;
  sweep_res_t       head;
  sweep_res_t       push_data;

  always_comb begin
    inflight = '0;
    for (int i = 0; i <= QUADRA_LAT; i++)
      inflight = inflight + PW'(tag_q[i].valid);
  end

  // A pop in this cycle is not credited back until next cycle.
  assign credit_ok = (inflight + PW'(fifo_cnt)) < PW'(FIFO_DEPTH);
  assign x_nxt     = load ? cmd_start : q_x + step_q;

  always_comb begin
    state_d  = state_q;
    issue    = 1'b0;
    load     = 1'b0;
    last_iss = 1'b0;
    done_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          if (cmd_count == '0) begin
            done_d = 1'b1;
          end else begin
            load     = 1'b1;
            issue    = 1'b1;
            last_iss = (cmd_count == CNT_W'(1));
            state_d  = last_iss ? S_DRAIN : S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (credit_ok) begin
          issue    = 1'b1;
          last_iss = (rem_q == CNT_W'(1));
          if (last_iss)
            state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pop && head.last) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(negedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= S_IDLE;
      q_x     <= '0;
      step_q  <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      if (load)
        step_q <= cmd_step;
      if (issue) begin
        q_x   <= x_nxt;
        rem_q <= load ? cmd_count - 1'b1
                      : rem_q - 1'b1;
      end
    end
  end

  // Stage 0 lines up with q_x, stage QUADRA_LAT with q_y.
  always_ff @(negedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i <= QUADRA_LAT; i++)
        tag_q[i] <= '0;
    end else begin
      tag_q[0] <= '{valid: issue, x: x_nxt,
                    last: last_iss};
      for (int i = 1; i <= QUADRA_LAT; i++)
        tag_q[i] <= tag_q[i-1];
    end
  end

  assign push      = tag_q[QUADRA_LAT].valid;
  assign push_data = '{x: tag_q[QUADRA_LAT].x, y: q_y,
                       last: tag_q[QUADRA_LAT].last};

  quadra_res_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_b     (rst_b),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (fifo_cnt)
  );

  assign out_valid = (fifo_cnt != '0);
  assign pop       = out_valid && out_ready;
  assign out_x     = out_valid ? head.x : '0;
  assign out_y     = out_valid ? head.y : '0;
  assign out_last  = out_valid && head.last;
  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = !cmd_ready;
  assign done      = done_q;

endmodule
